// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit.
//   - Host command byte codes (run, step, pause, dump).
//   - Command FSM state encoding.
//   - Default frame header byte.
//   - Helper that gives the number of bytes needed to carry a bus of a given width.
package debug_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
    localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        STEP = 3'd2,
        SNAP = 3'd3,
        SEND = 3'd4
    } state_t;

    // Number of whole bytes needed to carry bus_w bits.
    function automatic int nbytes(input int bus_w);
        return (bus_w + 7) / 8;
    endfunction

endpackage

// File: rtl/debug_serializer.sv
// Snapshot-and-stream engine for the datapath status bus.
// A one-cycle load pulse captures dp_bus into a zero-extended shadow register
// and presents the header byte. Each accepted byte advances to the next shadow
// byte, LSB byte first. done pulses (combinationally) on the cycle the final
// byte is accepted; tx_valid drops on that same edge.
//
// Handshake: a byte transfers on any cycle with tx_valid=1 and tx_ready=1.
// Once tx_valid is raised, tx_valid and tx_data hold until that transfer.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            one-cycle start pulse; samples dp_bus
//   dp_bus          datapath status bus
//   tx_ready        UART can take a byte
//   tx_valid        tx_data valid
//   tx_data         byte being offered
//   done            high on the cycle the last byte is accepted
module debug_serializer
    import debug_pkg::*;
#(
    parameter int          BUS_W    = 1401,
    parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BUS_W-1:0] dp_bus,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic             done
);

    localparam int NBYTES = nbytes(BUS_W);
    localparam int SH_W   = NBYTES * 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES);

    logic [SH_W-1:0]  shadow;
    logic [IDX_W-1:0] idx;      // 0 = header on the wire, k = shadow byte k-1
    logic             xfer;
    logic [7:0]       next_byte;

    assign xfer = tx_valid && tx_ready;
    assign done = xfer && (idx == LAST_IDX);

    // The byte that follows the one currently offered is shadow byte idx.
    always_comb begin
        next_byte = 8'h00;
        if (idx < LAST_IDX) begin
            next_byte = shadow[int'(idx) * 8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow   <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (load) begin
            // Unsigned cast zero-fills the pad bits of the last byte.
            shadow   <= SH_W'(dp_bus);
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= HDR_BYTE;
        end else if (xfer) begin
            if (idx == LAST_IDX) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= next_byte;
                idx     <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Debug unit controller between the UART byte interface and the datapath.
// Decodes single-byte host commands (run, step, pause, dump), gates the
// datapath through a registered clock enable, and dumps a snapshot of the
// datapath status bus as a framed byte stream (header + NBYTES bytes).
//
// Handshake: a byte transfers on any cycle with tx_valid=1 and tx_ready=1;
// tx_valid/tx_data are held unchanged until that transfer.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   rx_rdy, rx_data one-cycle strobe and received command byte
//   dp_bus          datapath status bus (sampled in SNAP only)
//   halt_in         datapath has halted (level)
//   tx_ready        UART can accept a byte
//   tx_valid        tx_data valid
//   tx_data         byte to transmit
//   dp_en           datapath clock enable (registered)
//   dumping         high in SNAP and SEND
//   state           current command FSM state (debug visibility)
module debug_unit_ctrl
    import debug_pkg::*;
#(
    parameter int         BUS_W       = 1401,
    parameter int         STEP_CYCLES = 1,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_rdy,
    input  logic [7:0]       rx_data,
    input  logic [BUS_W-1:0] dp_bus,
    input  logic             halt_in,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic             dp_en,
    output logic             dumping,
    output state_t           state
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic [STEP_W-1:0] step_cnt;
    logic              load;
    logic              done;

    // SNAP lasts exactly one cycle, so this is a one-cycle pulse. dp_en is
    // already low by then, so the sampled bus is stable.
    assign load = (state == SNAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            dp_en    <= 1'b0;
            dumping  <= 1'b0;
            step_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dp_en <= 1'b0;
                    if (rx_rdy) begin
                        // A halted program stays halted: run/step are refused.
                        if (rx_data == CMD_RUN && !halt_in) begin
                            state <= RUN;
                            dp_en <= 1'b1;
                        end else if (rx_data == CMD_STEP && !halt_in) begin
                            state    <= STEP;
                            dp_en    <= 1'b1;
                            step_cnt <= '0;
                        end else if (rx_data == CMD_DUMP) begin
                            state   <= SNAP;
                            dumping <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // halt and pause together still produce one dump.
                    if (halt_in || (rx_rdy && rx_data == CMD_PAUSE)) begin
                        state   <= SNAP;
                        dp_en   <= 1'b0;
                        dumping <= 1'b1;
                    end
                end
                STEP: begin
                    // step_cnt counts enabled cycles already completed.
                    if (halt_in || step_cnt == STEP_LAST) begin
                        state   <= SNAP;
                        dp_en   <= 1'b0;
                        dumping <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                SNAP: begin
                    state <= SEND;
                end
                SEND: begin
                    dp_en <= 1'b0;
                    if (done) begin
                        state   <= IDLE;
                        dumping <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dp_en   <= 1'b0;
                    dumping <= 1'b0;
                end
            endcase
        end
    end

    debug_serializer #(
        .BUS_W    (BUS_W),
        .HDR_BYTE (HDR_BYTE)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dp_bus   (dp_bus),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .done     (done)
    );

endmodule

// File: tb/tb_debug_unit_ctrl.sv
module tb_debug_unit_ctrl;
    import debug_pkg::*;

    localparam int BUS_W       = 20;
    localparam int STEP_CYCLES = 2;
    localparam int NB          = (BUS_W + 7) / 8;
    localparam int WAIT_MAX    = 400;

    // ---------------- clock / reset / DUT ----------------
    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             rx_rdy   = 1'b0;
    logic [7:0]       rx_data  = 8'h00;
    logic [BUS_W-1:0] dp_bus   = '0;
    logic             halt_in  = 1'b0;
    logic             tx_ready = 1'b0;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             dp_en;
    logic             dumping;
    state_t           state;

    always #5 clk = ~clk;

    debug_unit_ctrl #(
        .BUS_W       (BUS_W),
        .STEP_CYCLES (STEP_CYCLES),
        .HDR_BYTE    (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .dp_bus   (dp_bus),
        .halt_in  (halt_in),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .dp_en    (dp_en),
        .dumping  (dumping),
        .state    (state)
    );

    // ---------------- scoreboard state ----------------
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         en_cnt  = 0;   // dp_en-high cycles seen
    int         xfer_cnt = 0;  // accepted bytes seen
    int         ready_mode = 0; // 0: always ready, 1: 1-0-0-1 pattern, 2: random
    int         pat_i = 0;
    logic [3:0] ready_pat = 4'b1001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: header, then the bus value cut into bytes, low byte first.
    task automatic push_frame(input logic [BUS_W-1:0] v);
        int val;
        val = int'(v);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(8'((val >> (8 * i)) & 255));
        end
    endtask

    // ---------------- tx_ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1: begin
                tx_ready = ready_pat[3 - (pat_i % 4)];
                pat_i++;
            end
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- monitor ----------------
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (dp_en) en_cnt++;
            if (prev_hold) begin
                check("tx_valid_held", 32'(tx_valid), 32'd1);
                check("tx_data_held", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got byte %02h, expected no transfer (t=%0t)", tx_data, $time);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_rdy  = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(state == IDLE && !tx_valid && exp_q.size() == 0) && n < WAIT_MAX) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= WAIT_MAX) begin
            fails++;
            $display("FAIL %s_timeout: state=%0d tx_valid=%0b pending=%0d, expected idle with empty queue",
                     name, state, tx_valid, exp_q.size());
        end
        check({name, "_dumping"}, 32'(dumping), 32'd0);
    endtask

    task automatic wait_en_low(input string name);
        int n;
        n = 0;
        while (dp_en && n < WAIT_MAX) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= WAIT_MAX) begin
            fails++;
            $display("FAIL %s_en_timeout: dp_en still %0b, expected low", name, dp_en);
        end
    endtask

    // Called right after the stop condition was seen: bus is snapshotted on the next edge.
    task automatic snap_with(input string name, input logic [BUS_W-1:0] v);
        check({name, "_in_snap"}, 32'(state), 32'(SNAP));
        check({name, "_dumping_snap"}, 32'(dumping), 32'd1);
        dp_bus = v;
        push_frame(v);
    endtask

    // ---------------- main sequence ----------------
    logic [BUS_W-1:0] v;
    logic [7:0]       noise [4] = '{8'h43, 8'h53, 8'h44, 8'h50};

    initial begin
        // reset
        #1 rst = 1'b0;
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_dp_en", 32'(dp_en), 32'd0);
        check("rst_dumping", 32'(dumping), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        cycles(3);
        rst = 1'b1;
        cycles(2);

        // plain dump
        en_cnt = 0;
        send_cmd(CMD_DUMP);
        snap_with("dump", 20'hABCDE);
        wait_idle("dump");
        check("dump_en_cnt", 32'(en_cnt), 32'd0);
        check("dump_state", 32'(state), 32'(IDLE));

        // step: bus is garbage while enabled, real value once dp_en fell
        en_cnt = 0;
        send_cmd(CMD_STEP);
        dp_bus = 20'h13579;
        wait_en_low("step");
        snap_with("step", BUS_W'($urandom));
        wait_idle("step");
        check("step_en_cnt", 32'(en_cnt), 32'(STEP_CYCLES));

        // run, halt 10 cycles later
        en_cnt = 0;
        send_cmd(CMD_RUN);
        cycles(10);
        halt_in = 1'b1;
        cycles(1);
        check("halt_dp_en_fall", 32'(dp_en), 32'd0);
        snap_with("halt", BUS_W'($urandom));
        wait_idle("halt");
        check("halt_en_cnt", 32'(en_cnt), 32'd11);

        // halted: run and step are refused
        en_cnt = 0;
        send_cmd(CMD_RUN);
        cycles(4);
        send_cmd(CMD_STEP);
        cycles(4);
        check("halted_en_cnt", 32'(en_cnt), 32'd0);
        check("halted_state", 32'(state), 32'(IDLE));
        halt_in = 1'b0;

        // dump under 1-0-0-1 backpressure with a run command injected
        ready_mode = 1;
        en_cnt = 0;
        send_cmd(CMD_DUMP);
        snap_with("bp", BUS_W'($urandom));
        send_cmd(CMD_RUN);
        dp_bus = BUS_W'($urandom);
        wait_idle("bp");
        cycles(3);
        check("bp_en_cnt", 32'(en_cnt), 32'd0);
        check("bp_state", 32'(state), 32'(IDLE));
        ready_mode = 0;

        // reset while the third byte is on the wire
        xfer_cnt = 0;
        send_cmd(CMD_DUMP);
        snap_with("rstmid", BUS_W'($urandom));
        begin
            int n;
            n = 0;
            while (xfer_cnt < 2 && n < WAIT_MAX) begin
                @(posedge clk);
                n++;
            end
            check("rstmid_reach_byte3", 32'(xfer_cnt), 32'd2);
        end
        #2 rst = 1'b0;
        #1;
        check("rstmid_tx_valid", 32'(tx_valid), 32'd0);
        check("rstmid_dp_en", 32'(dp_en), 32'd0);
        check("rstmid_dumping", 32'(dumping), 32'd0);
        check("rstmid_state", 32'(state), 32'(IDLE));
        exp_q.delete();
        cycles(2);
        rst = 1'b1;
        cycles(2);
        send_cmd(CMD_DUMP);
        snap_with("postrst", BUS_W'($urandom));
        wait_idle("postrst");

        // run, then pause and halt in the same cycle: a single frame
        en_cnt = 0;
        send_cmd(CMD_RUN);
        cycles(3);
        @(posedge clk);
        #1;
        rx_rdy  = 1'b1;
        rx_data = CMD_PAUSE;
        halt_in = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        snap_with("ph", BUS_W'($urandom));
        wait_idle("ph");
        cycles(8);
        check("ph_en_cnt", 32'(en_cnt), 32'd5);
        halt_in = 1'b0;

        // unknown code in IDLE
        send_cmd(8'h00);
        cycles(5);
        check("unk_state", 32'(state), 32'(IDLE));
        check("unk_dp_en", 32'(dp_en), 32'd0);
        check("unk_tx_valid", 32'(tx_valid), 32'd0);

        // randomized commands, backpressure and noise
        for (int it = 0; it < 10; it++) begin
            int kind;
            int k;
            kind = $urandom_range(0, 2);
            ready_mode = $urandom_range(0, 2);
            v = BUS_W'($urandom);
            en_cnt = 0;
            if (kind == 0) begin
                send_cmd(CMD_DUMP);
                snap_with("rnd_d", v);
                k = 0;
            end else if (kind == 1) begin
                send_cmd(CMD_STEP);
                dp_bus = ~v;
                wait_en_low("rnd_s");
                snap_with("rnd_s", v);
                k = STEP_CYCLES;
            end else begin
                k = $urandom_range(1, 6);
                send_cmd(CMD_RUN);
                cycles(k);
                send_cmd(CMD_PAUSE);
                snap_with("rnd_c", v);
                k = k + 2;
            end
            // after the snapshot: bus changes and rx bytes must not matter
            send_cmd(noise[$urandom_range(0, 3)]);
            dp_bus = BUS_W'($urandom);
            wait_idle("rnd");
            check("rnd_en_cnt", 32'(en_cnt), 32'(k));
        end
        ready_mode = 0;
        cycles(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_unit_ctrl.md
Name: debug_unit_ctrl

Overview:
- Parametrised successor of the MIPS debug unit; sits between the UART byte interface and the datapath.
- Decodes single-byte host commands: run, step, pause, dump.
- Gates the datapath with a clock enable instead of a derived clock.
- Snapshots a BUS_W-bit datapath status bus and streams it to the UART as a framed byte sequence using a valid/ready handshake.

Parameters:
- BUS_W, 1401, width of datapath status bus; NBYTES = ceil(BUS_W/8).
- STEP_CYCLES, 1, dp_en cycles issued per step command (>=1).
- HDR_BYTE, 8'hA5, frame header sent before every dump.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_rdy  in  1  one-cycle strobe: rx_data valid.
- rx_data  in  8  received command byte.
- dp_bus  in  BUS_W  datapath status bus, sampled only at snapshot.
- halt_in  in  1  datapath reached HALT (level).
- tx_ready  in  1  UART can accept a byte.
- tx_valid  out  1  tx_data valid, held until accepted.
- tx_data  out  8  byte to transmit.
- dp_en  out  1  datapath clock enable, registered.
- dumping  out  1  high in SNAP/SEND states.

Behaviour:
- Reset (rst=0, async): state=IDLE, dp_en=0, tx_valid=0, tx_data=0, dumping=0, byte index=0, step count=0, shadow register=0.
- Command codes: 'C'=8'h43 run, 'S'=8'h53 step, 'P'=8'h50 pause, 'D'=8'h44 dump. Any other code is ignored.
- Handshake: a byte transfers on a cycle where tx_valid=1 and tx_ready=1. tx_valid and tx_data must not change until that transfer.
- IDLE: dp_en=0.
  - 'C' -> RUN.
  - 'S' -> STEP, step count=0.
  - 'D' -> SNAP.
  - 'C' and 'S' are ignored while halt_in=1; a program that has halted stays halted until datapath reset.
- RUN: dp_en=1 from the next cycle.
  - halt_in=1 -> SNAP, dp_en=0 on the following edge.
  - rx 'P' -> SNAP, same timing.
  - halt_in and 'P' in the same cycle: a single dump.
  - Other rx bytes are ignored.
- STEP: dp_en=1 for exactly STEP_CYCLES cycles, then SNAP.
  - halt_in=1 ends the step early -> SNAP.
  - rx bytes are ignored.
- SNAP (one cycle): shadow <= dp_bus zero-extended to NBYTES*8; index=0; -> SEND.
- SEND:
  - Sends HDR_BYTE first, then shadow bytes 0..NBYTES-1 (LSB byte first). Total NBYTES+1 transfers.
  - Advance only on a transfer.
  - After the last transfer: tx_valid=0 -> IDLE.
  - dp_en=0 and all rx bytes are dropped (no queueing).
  - tx_ready stuck low: SEND waits indefinitely; no timeout.
- dumping=1 in SNAP and SEND, 0 elsewhere.
- The snapshot is taken after dp_en has fallen, so the bus is stable. dp_bus changes during SEND do not affect the dump.
- Byte index width is clog2(NBYTES+1). When BUS_W is not a multiple of 8, the pad bits in the last byte are 0.
- Reset asserted mid-dump or mid-run: immediate return to reset values; no partial frame completes.

Decomposition:
- Shared package debug_pkg holds:
  - command byte constants CMD_RUN, CMD_STEP, CMD_PAUSE, CMD_DUMP;
  - the state enum IDLE/RUN/STEP/SNAP/SEND;
  - the default HDR_BYTE.
- One natural sub-module, debug_serializer: shadow register, byte index, byte mux and valid/ready logic. It is started by a one-cycle load pulse and returns a done pulse.
- The command FSM and the dp_en/step counter stay in debug_unit_ctrl.

Test Plan (BUS_W=20, so NBYTES=3; STEP_CYCLES=2):
- Reset then 'D', dp_bus=20'hABCDE, tx_ready=1 -> tx bytes A5, DE, BC, 0A; tx_valid low afterwards; dp_en stays 0; state IDLE.
- 'S' from IDLE -> dp_en high exactly 2 cycles; then frame A5 plus 3 bytes of dp_bus as sampled after dp_en fell.
- 'C', halt_in raised 10 cycles later -> dp_en falls on the next edge; one frame sent; then 'C' with halt_in=1 -> dp_en stays 0.
- During a dump, toggle tx_ready 1-0-0-1 each cycle and inject rx 'C' -> tx_data stable while not accepted; no byte lost or duplicated; 'C' dropped; IDLE at end.
- Assert rst=0 in the middle of the third byte -> tx_valid=0, dp_en=0 asynchronously; after release, 'D' sends a full fresh 4-byte frame.
- 'C' then simultaneous 'P' and halt_in -> exactly one frame; rx 8'h00 in IDLE -> no response.
